// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, digit
// width and the per-mode digit maximum.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // Hex displays use the full nibble; everything else counts in decimal.
  function automatic logic [DIGIT_W-1:0] digit_max_f(input logic hex_mode);
    return hex_mode ? 4'd15 : 4'd9;
  endfunction

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                     input logic [DIGIT_W-1:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One down-counting digit. Decrements when a borrow arrives from the digit
// below, wraps 0 -> DIGIT_MAX and passes the borrow upward combinationally.
module bcd_down_digit
  import bcd_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_load,
  input  logic [DIGIT_W-1:0] i_load_value,
  input  logic               i_borrow_in,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_borrow_out,
  output logic               o_is_zero
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  // Next digit value: load (clamped) has precedence over a borrow.
  always_comb begin
    digit_d = digit_q;
    if (i_load) begin
      digit_d = clamp_digit(i_load_value, DIGIT_MAX);
    end else if (i_borrow_in) begin
      digit_d = (digit_q == '0) ? DIGIT_MAX : digit_q - 1'b1;
    end
  end

  // Digit register.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign o_digit      = digit_q;
  assign o_is_zero    = (digit_q == '0);
  assign o_borrow_out = i_borrow_in & o_is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Cascaded BCD/hex countdown timer with load, start/pause and a one-cycle
// terminal-count pulse.
//
//   state      | meaning
//   -----------+------------------------------------------
//   ST_IDLE    | loaded or reset, not counting
//   ST_RUN     | counting on each tick
//   ST_PAUSED  | value held, waiting for start
//   ST_EXPIRED | reached zero and stopped
//
// NUM_DIGITS is meant for 1..8.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int    NUM_DIGITS   = 4,
  parameter string DISPLAY_MODE = "DECIMAL",
  parameter bit    AUTO_RELOAD  = 1'b0
) (
  input  logic                          i_CLK,
  input  logic                          i_RST_N,
  input  logic                          i_LOAD,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_LOAD_VALUE,
  input  logic                          i_START,
  input  logic                          i_PAUSE,
  input  logic                          i_TICK,
  output logic [NUM_DIGITS*DIGIT_W-1:0] o_COUNT,
  output logic                          o_BUSY,
  output logic                          o_DONE,
  output logic                          o_EXPIRED
);

  localparam int CW = NUM_DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = digit_max_f(DISPLAY_MODE == "HEXADECIMAL");

  state_e          state_q, state_d;
  logic            done_q, done_d;
  logic [CW-1:0]   reload_q, reload_d;

  logic [CW-1:0]         preset_clamped;
  logic [CW-1:0]         digit_load_value;
  logic [CW-1:0]         count;
  logic [NUM_DIGITS-1:0] is_zero;
  logic [NUM_DIGITS:0]   borrow;
  logic                  digit_load;
  logic                  use_reload;
  logic                  dec_en;
  logic                  upper_zero;
  logic                  count_zero;
  logic                  count_is_one;
  logic                  reload_zero;
  logic                  unused_borrow;

  // Clamp the preset digit-wise so the reload register never holds an
  // out-of-range digit.
  always_comb begin
    preset_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      preset_clamped[i*DIGIT_W +: DIGIT_W] = clamp_digit(i_LOAD_VALUE[i*DIGIT_W +: DIGIT_W], DIGIT_MAX);
    end
  end

  assign digit_load_value = use_reload ? reload_q : preset_clamped;
  assign borrow[0]        = dec_en;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_down_digit #(
        .DIGIT_MAX (DIGIT_MAX)
      ) u_digit (
        .i_CLK        (i_CLK),
        .i_RST_N      (i_RST_N),
        .i_load       (digit_load),
        .i_load_value (digit_load_value[g*DIGIT_W +: DIGIT_W]),
        .i_borrow_in  (borrow[g]),
        .o_digit      (count[g*DIGIT_W +: DIGIT_W]),
        .o_borrow_out (borrow[g+1]),
        .o_is_zero    (is_zero[g])
      );
    end
  endgenerate

  // The top digit's borrow would signal underflow, which the FSM prevents.
  assign unused_borrow = borrow[NUM_DIGITS];

  // Zero detect on the digits above digit 0, for the terminal "count = 1" test.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      upper_zero = upper_zero & is_zero[i];
    end
  end

  assign count_zero   = &is_zero;
  assign count_is_one = upper_zero && (count[DIGIT_W-1:0] == 4'd1);
  assign reload_zero  = (reload_q == '0);

  // Next-state, reload register and digit-control decode.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    reload_d   = reload_q;
    digit_load = 1'b0;
    use_reload = 1'b0;
    dec_en     = 1'b0;

    if (i_LOAD) begin
      reload_d   = preset_clamped;
      digit_load = 1'b1;
      state_d    = ST_IDLE;
    end else if (i_START && (state_q != ST_RUN)) begin
      if (state_q == ST_EXPIRED) begin
        // An empty reload register cannot run; report expiry again instead.
        if (reload_zero) begin
          done_d = 1'b1;
        end else begin
          digit_load = 1'b1;
          use_reload = 1'b1;
          state_d    = ST_RUN;
        end
      end else if (count_zero) begin
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (i_PAUSE && (state_q == ST_RUN)) begin
      state_d = ST_PAUSED;
    end else if (i_TICK && (state_q == ST_RUN)) begin
      if (count_is_one) begin
        done_d = 1'b1;
        if (AUTO_RELOAD && !reload_zero) begin
          digit_load = 1'b1;
          use_reload = 1'b1;
        end else begin
          dec_en  = 1'b1;
          state_d = ST_EXPIRED;
        end
      end else if (!count_zero) begin
        dec_en = 1'b1;
      end
    end
  end

  // State, done pulse and reload register.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      reload_q <= reload_d;
    end
  end

  assign o_COUNT   = count;
  assign o_BUSY    = (state_q == ST_RUN);
  assign o_EXPIRED = (state_q == ST_EXPIRED);
  assign o_DONE    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: three 2-digit variants (decimal, hex,
// decimal auto-reload) share one stimulus stream and are checked every cycle
// against an integer-valued reference model.
module tb_bcd_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       i_LOAD;
  logic [7:0] i_LOAD_VALUE;
  logic       i_START;
  logic       i_PAUSE;
  logic       i_TICK;

  logic [7:0] cnt  [3];
  logic       busy [3];
  logic       done [3];
  logic       expd [3];

  int checks = 0;
  int errors = 0;

  // Reference model: value held as a plain integer in the variant's radix.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
  int radix [3] = '{10, 16, 10};
  bit autor [3] = '{1'b0, 1'b0, 1'b1};
  int m_state [3];
  int m_val   [3];
  int m_rel   [3];
  bit m_done  [3];

  bcd_countdown_timer #(.NUM_DIGITS(2), .DISPLAY_MODE("DECIMAL"), .AUTO_RELOAD(1'b0)) dut_dec (
    .i_CLK(clk), .i_RST_N(rst_n), .i_LOAD(i_LOAD), .i_LOAD_VALUE(i_LOAD_VALUE),
    .i_START(i_START), .i_PAUSE(i_PAUSE), .i_TICK(i_TICK),
    .o_COUNT(cnt[0]), .o_BUSY(busy[0]), .o_DONE(done[0]), .o_EXPIRED(expd[0]));

  bcd_countdown_timer #(.NUM_DIGITS(2), .DISPLAY_MODE("HEXADECIMAL"), .AUTO_RELOAD(1'b0)) dut_hex (
    .i_CLK(clk), .i_RST_N(rst_n), .i_LOAD(i_LOAD), .i_LOAD_VALUE(i_LOAD_VALUE),
    .i_START(i_START), .i_PAUSE(i_PAUSE), .i_TICK(i_TICK),
    .o_COUNT(cnt[1]), .o_BUSY(busy[1]), .o_DONE(done[1]), .o_EXPIRED(expd[1]));

  bcd_countdown_timer #(.NUM_DIGITS(2), .DISPLAY_MODE("DECIMAL"), .AUTO_RELOAD(1'b1)) dut_ar (
    .i_CLK(clk), .i_RST_N(rst_n), .i_LOAD(i_LOAD), .i_LOAD_VALUE(i_LOAD_VALUE),
    .i_START(i_START), .i_PAUSE(i_PAUSE), .i_TICK(i_TICK),
    .o_COUNT(cnt[2]), .o_BUSY(busy[2]), .o_DONE(done[2]), .o_EXPIRED(expd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd_to_int(input logic [7:0] v, input int r);
    int d0, d1;
    d0 = int'(v[3:0]);
    d1 = int'(v[7:4]);
    if (d0 > r - 1) d0 = r - 1;
    if (d1 > r - 1) d1 = r - 1;
    return d1 * r + d0;
  endfunction

  function automatic logic [7:0] int_to_bcd(input int v, input int r);
    logic [3:0] hi, lo;
    lo = 4'(v % r);
    hi = 4'(v / r);
    return {hi, lo};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_state[k] = M_IDLE; m_val[k] = 0; m_rel[k] = 0; m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic ld, input logic [7:0] lv, input logic st,
                            input logic pa, input logic tk);
    for (int k = 0; k < 3; k++) begin
      m_done[k] = 1'b0;
      if (ld) begin
        m_val[k] = bcd_to_int(lv, radix[k]);
        m_rel[k] = m_val[k];
        m_state[k] = M_IDLE;
      end else if (st && m_state[k] != M_RUN) begin
        if (m_state[k] == M_EXP) begin
          if (m_rel[k] == 0) m_done[k] = 1'b1;
          else begin m_val[k] = m_rel[k]; m_state[k] = M_RUN; end
        end else if (m_val[k] == 0) begin
          m_state[k] = M_EXP; m_done[k] = 1'b1;
        end else begin
          m_state[k] = M_RUN;
        end
      end else if (pa && m_state[k] == M_RUN) begin
        m_state[k] = M_PAUSED;
      end else if (tk && m_state[k] == M_RUN) begin
        if (m_val[k] == 1) begin
          m_done[k] = 1'b1;
          if (autor[k] && m_rel[k] != 0) m_val[k] = m_rel[k];
          else begin m_val[k] = 0; m_state[k] = M_EXP; end
        end else if (m_val[k] > 0) begin
          m_val[k] = m_val[k] - 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_count"},   k, cnt[k], int_to_bcd(m_val[k], radix[k]));
      chk({tag, "_busy"},    k, 8'(busy[k]), 8'(m_state[k] == M_RUN));
      chk({tag, "_expired"}, k, 8'(expd[k]), 8'(m_state[k] == M_EXP));
      chk({tag, "_done"},    k, 8'(done[k]), 8'(m_done[k]));
    end
  endtask

  task automatic cyc(input string tag, input logic ld, input logic [7:0] lv,
                     input logic st, input logic pa, input logic tk);
    i_LOAD = ld; i_LOAD_VALUE = lv; i_START = st; i_PAUSE = pa; i_TICK = tk;
    @(posedge clk);
    #1;
    model_step(ld, lv, st, pa, tk);
    check_all(tag);
    i_LOAD = 1'b0; i_START = 1'b0; i_PAUSE = 1'b0; i_TICK = 1'b0;
  endtask

  initial begin
    int r;
    logic [7:0] lv;

    rst_n = 1'b1;
    i_LOAD = 1'b0; i_LOAD_VALUE = 8'h00; i_START = 1'b0; i_PAUSE = 1'b0; i_TICK = 1'b0;
    model_reset();

    #2 rst_n = 1'b0;
    #1 check_all("reset");
    @(posedge clk); @(posedge clk); #1;
    check_all("reset_hold");
    rst_n = 1'b1;

    // Decimal wrap / hex borrow.
    cyc("wrap_load", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    cyc("wrap_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("wrap_t1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("wrap_dec", 0, cnt[0], 8'h09);
    chk("wrap_hex", 1, cnt[1], 8'h0F);
    cyc("wrap_t2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("wrap_dec2", 0, cnt[0], 8'h08);

    // Expiry, ticks after expiry, restart from EXPIRED.
    cyc("exp_load", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    cyc("exp_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc("exp_tick", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("exp_done", 0, 8'(done[0]), 8'h01);
    chk("exp_flag", 0, 8'(expd[0]), 8'h01);
    chk("exp_cnt", 0, cnt[0], 8'h00);
    repeat (2) cyc("exp_more", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc("exp_restart", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("exp_restart_cnt", 0, cnt[0], 8'h03);

    // Pause holds the value.
    cyc("pa_load", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    cyc("pa_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc("pa_tick", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc("pa_pause", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc("pa_held", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("pa_hold", 0, cnt[0], 8'h03);
    cyc("pa_resume", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("pa_tick2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("pa_after", 0, cnt[0], 8'h02);

    // Clamp on load.
    cyc("clamp", 1'b1, 8'hAF, 1'b0, 1'b0, 1'b0);
    chk("clamp_dec", 0, cnt[0], 8'h99);
    chk("clamp_hex", 1, cnt[1], 8'hAF);

    // Auto-reload.
    cyc("ar_load", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    cyc("ar_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc("ar_tick", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("ar_busy", 2, 8'(busy[2]), 8'h01);
    end
    chk("ar_cnt", 2, cnt[2], 8'h02);

    // Asynchronous reset mid-run.
    cyc("rst_load", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    cyc("rst_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("rst_tick", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    @(posedge clk); #1;
    check_all("rst_held");
    rst_n = 1'b1;
    cyc("rst_after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Load racing the terminal tick.
    cyc("race_load", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    cyc("race_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("race", 1'b1, 8'h07, 1'b0, 1'b0, 1'b1);
    chk("race_done", 0, 8'(done[0]), 8'h00);
    chk("race_cnt", 0, cnt[0], 8'h07);

    // Start with zero count from IDLE.
    cyc("zero_load", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("zero_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("zero_restart", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Randomised single-control cycles.
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      lv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      if (r < 5)       cyc("rnd", 1'b1, lv, 1'b0, 1'b0, 1'b0);
      else if (r < 12) cyc("rnd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      else if (r < 16) cyc("rnd", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      else if (r < 80) cyc("rnd", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      else             cyc("rnd", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
